// File: rtl/reset_sequencer.sv
// Ordered per-domain reset release: hold, then release one domain per ready ack.
// Optional ready timeout with ERR_O when RESET_SEQ_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module reset_sequencer #(
  parameter int OUTPUTS     = 4,
  parameter int HOLD_CYC    = 8,
  parameter int GAP_CYC     = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               CLK_I,
  input  logic               ARESETN_I,
  input  logic               SW_RST_I,
  input  logic [OUTPUTS-1:0] READY_I,
  output logic [OUTPUTS-1:0] RESETN_O,
  output logic               DONE_O,
  output logic               ERR_O
);

  localparam int MAX_HG =
    (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int MAX_C =
    (MAX_HG > TIMEOUT_CYC) ? MAX_HG : TIMEOUT_CYC;
  localparam int CW = $clog2(MAX_C + 1);
  localparam int SW =
    (OUTPUTS > 1) ? $clog2(OUTPUTS) : 1;

  typedef enum logic [2:0] {
    S_HOLD,
    S_WAIT,
    S_GAP,
    S_DONE
`ifdef RESET_SEQ_TIMEOUT_EN
    , S_ERROR
`endif
  } state_t;

  state_t             state_q, state_n;
  logic [CW-1:0]      cnt_q, cnt_n;
  logic [SW-1:0]      stage_q, stage_n;
  logic [SW-1:0]      stage_nx;
  logic [OUTPUTS-1:0] resetn_q, resetn_n;
  logic               done_q, done_n;
  logic               ready_k;
  logic               last;

  assign ready_k  = READY_I[stage_q];
  assign last     = (stage_q == SW'(OUTPUTS - 1));
  assign stage_nx = stage_q + 1'b1;

`ifdef RESET_SEQ_TIMEOUT_EN
  logic err_q, err_n;
`endif

  always_ff @(posedge CLK_I or negedge ARESETN_I) begin
    if (!ARESETN_I) begin
      state_q  <= S_HOLD;
      cnt_q    <= '0;
      stage_q  <= '0;
      resetn_q <= '0;
      done_q   <= 1'b0;
`ifdef RESET_SEQ_TIMEOUT_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      stage_q  <= stage_n;
      resetn_q <= resetn_n;
      done_q   <= done_n;
`ifdef RESET_SEQ_TIMEOUT_EN
      err_q    <= err_n;
`endif
    end
  end

  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    stage_n  = stage_q;
    resetn_n = resetn_q;
    done_n   = done_q;
`ifdef RESET_SEQ_TIMEOUT_EN
    err_n    = err_q;
`endif
    if (SW_RST_I) begin
      state_n  = S_HOLD;
      cnt_n    = '0;
      stage_n  = '0;
      resetn_n = '0;
      done_n   = 1'b0;
`ifdef RESET_SEQ_TIMEOUT_EN
      err_n    = 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_HOLD: begin
          if (cnt_q == CW'(HOLD_CYC - 1)) begin
            resetn_n = resetn_q | OUTPUTS'(1);
            cnt_n    = '0;
            state_n  = S_WAIT;
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end
        S_WAIT: begin
          if (ready_k) begin
            if (last) begin
              done_n  = 1'b1;
              state_n = S_DONE;
            end else begin
              cnt_n   = '0;
              state_n = S_GAP;
            end
          end
`ifdef RESET_SEQ_TIMEOUT_EN
          else if (cnt_q == CW'(TIMEOUT_CYC)) begin
            err_n   = 1'b1;
            state_n = S_ERROR;
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
`endif
        end
        S_GAP: begin
          if (cnt_q == CW'(GAP_CYC - 1)) begin
            resetn_n = resetn_q
                     | (OUTPUTS'(1) << stage_nx);
            stage_n  = stage_nx;
            cnt_n    = '0;
            state_n  = S_WAIT;
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          state_n = S_DONE;
        end
`ifdef RESET_SEQ_TIMEOUT_EN
        S_ERROR: begin
          state_n = S_ERROR;
        end
`endif
        default: begin
          state_n = S_HOLD;
        end
      endcase
    end
  end

  assign RESETN_O = resetn_q;
  assign DONE_O   = done_q;
`ifdef RESET_SEQ_TIMEOUT_EN
  assign ERR_O    = err_q;
`else
  assign ERR_O    = 1'b0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer at default parameters.
// Covers power-up, async abort, ready gating, sw reset and stuck ready.
`timescale 1ns/1ps
module tb_reset_sequencer;

  logic       clk;
  logic       rst_n;
  logic       sw;
  logic [3:0] ready;
  logic [3:0] resetn;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  reset_sequencer dut (
    .CLK_I     (clk),
    .ARESETN_I (rst_n),
    .SW_RST_I  (sw),
    .READY_I   (ready),
    .RESETN_O  (resetn),
    .DONE_O    (done),
    .ERR_O     (err)
  );

  initial clk = 1'b0;
  always #2 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    sw    = 1'b0;
    ready = 4'hF;
    tick(2);
    chk("rst_resetn", 32'(resetn), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err", 32'(err), 32'h0);

    // 1: power-up with all ready
    rst_n = 1'b1;
    tick(7);
    chk("pu_e7", 32'(resetn), 32'h0);
    tick(1);
    chk("pu_e8", 32'(resetn), 32'h1);
    tick(4);
    chk("pu_e12", 32'(resetn), 32'h1);
    tick(1);
    chk("pu_e13", 32'(resetn), 32'h3);
    tick(4);
    chk("pu_e17", 32'(resetn), 32'h3);
    tick(1);
    chk("pu_e18", 32'(resetn), 32'h7);
    tick(5);
    chk("pu_e23", 32'(resetn), 32'hF);
    chk("pu_e23_done", 32'(done), 32'h0);
    tick(1);
    chk("pu_e24_done", 32'(done), 32'h1);
    chk("pu_err", 32'(err), 32'h0);

    // 2: async reset, then abort after domain 1 release
    rst_n = 1'b0;
    #1;
    chk("async_done", 32'(resetn), 32'h0);
    chk("async_done_d", 32'(done), 32'h0);
    tick(1);
    rst_n = 1'b1;
    tick(13);
    chk("ab_e13", 32'(resetn), 32'h3);
    rst_n = 1'b0;
    #1;
    chk("ab_async", 32'(resetn), 32'h0);
    chk("ab_done", 32'(done), 32'h0);
    tick(1);

    // 3: ready[1] late, ready[2] early
    ready = 4'b0101;
    rst_n = 1'b1;
    tick(7);
    chk("rg_e7", 32'(resetn), 32'h0);
    tick(1);
    chk("rg_e8", 32'(resetn), 32'h1);
    tick(5);
    chk("rg_e13", 32'(resetn), 32'h3);
    tick(50);
    chk("rg_e63", 32'(resetn), 32'h3);
    ready = 4'b0111;
    tick(4);
    chk("rg_e67", 32'(resetn), 32'h3);
    tick(1);
    chk("rg_e68", 32'(resetn), 32'h7);
    tick(5);
    chk("rg_e73", 32'(resetn), 32'hF);
    tick(2);
    chk("rg_nodone", 32'(done), 32'h0);
    ready = 4'hF;
    tick(1);
    chk("rg_done", 32'(done), 32'h1);

    // 4: sw reset pulse in DONE
    sw = 1'b1;
    tick(1);
    chk("sw_resetn", 32'(resetn), 32'h0);
    chk("sw_done", 32'(done), 32'h0);
    tick(2);
    chk("sw_hold", 32'(resetn), 32'h0);
    sw = 1'b0;
    tick(7);
    chk("sw_e7", 32'(resetn), 32'h0);
    tick(1);
    chk("sw_e8", 32'(resetn), 32'h1);

    // 5/6: ready[2] stuck low
    ready = 4'b1011;
    tick(10);
    chk("st_w2", 32'(resetn), 32'h7);
    chk("st_w2_err", 32'(err), 32'h0);
`ifdef RESET_SEQ_TIMEOUT_EN
    tick(1024);
    chk("to_pre", 32'(err), 32'h0);
    chk("to_pre_rn", 32'(resetn), 32'h7);
    tick(1);
    chk("to_err", 32'(err), 32'h1);
    chk("to_rn", 32'(resetn), 32'h7);
    ready = 4'hF;
    tick(6);
    chk("to_stay", 32'(err), 32'h1);
    chk("to_stay_rn", 32'(resetn), 32'h7);
    sw = 1'b1;
    tick(1);
    chk("to_clr", 32'(err), 32'h0);
    chk("to_clr_rn", 32'(resetn), 32'h0);
    sw = 1'b0;
    tick(8);
    chk("to_restart", 32'(resetn), 32'h1);
`else
    tick(1025);
    chk("nt_err", 32'(err), 32'h0);
    chk("nt_rn", 32'(resetn), 32'h7);
    ready = 4'hF;
    tick(4);
    chk("nt_gap", 32'(resetn), 32'h7);
    tick(1);
    chk("nt_rel", 32'(resetn), 32'hF);
    tick(1);
    chk("nt_done", 32'(done), 32'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
